if_fetch_unit: RTL and testbench

- Instruction-fetch stage of the 5-stage MIPS pipeline; producer side of the IF/ID interface.
- Owns the PC, issues word reads to instruction memory (one outstanding request max) and buffers returned words in a small FIFO.
- Presents {PC+4, instruction, valid} to the IF/ID register; honours the IF/ID write-block (stall) and the branch/jump redirect (flush) from the hazard/branch logic.

---
 rtl/if_fetch_unit_pkg.sv | 22 ++
 rtl/if_fetch_unit_if.sv | 26 ++
 rtl/if_fetch_unit_fetch_fifo.sv | 66 ++++++
 rtl/if_fetch_unit.sv | 89 ++++++++
 tb/tb_if_fetch_unit.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/if_fetch_unit_pkg.sv
// rtl/if_fetch_unit_pkg.sv - shared constants and types for the instruction fetch stage
package if_fetch_unit_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h0040_0000;
  localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_DISCARD = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc_4;
    logic [31:0] instr;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// rtl/if_fetch_unit_if.sv - IF/ID handshake and instruction memory port bundle
interface if_fetch_unit_if;

  logic        Block_IF_ID_Write;
  logic        Redirect;
  logic [31:0] Redirect_PC;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] out_PC_4;
  logic [31:0] out_Instruction;
  logic        out_Valid;

  modport master (
    input  Block_IF_ID_Write, Redirect, Redirect_PC, imem_gnt, imem_rvalid, imem_rdata,
    output imem_req, imem_addr, out_PC_4, out_Instruction, out_Valid
  );

  modport slave (
    output Block_IF_ID_Write, Redirect, Redirect_PC, imem_gnt, imem_rvalid, imem_rdata,
    input  imem_req, imem_addr, out_PC_4, out_Instruction, out_Valid
  );

endinterface

// File: rtl/if_fetch_unit_fetch_fifo.sv
// rtl/if_fetch_unit_fetch_fifo.sv - synchronous fetch buffer of {pc_4, instr} entries
module fetch_fifo
  import if_fetch_unit_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  fetch_entry_t  push_data,
  input  logic          pop,
  input  logic          flush,
  output logic [CW-1:0] count,
  output fetch_entry_t  head
);

  fetch_entry_t  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  // flush wins over a same-cycle push so a redirected stream never leaks a word
  always_comb begin
    do_push  = push && !flush;
    do_pop   = pop && !flush && (count_q != '0);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - MIPS IF stage: PC, single-outstanding imem fetch, buffered IF/ID feed
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
  parameter int          FIFO_DEPTH = 2
) (
  input logic             clk,
  input logic             reset,
  if_fetch_unit_if.master bus
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e  state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   req_pc_4_q, req_pc_4_d;
  logic [CW-1:0] fifo_count;
  fetch_entry_t  fifo_head, push_entry;
  logic          push, pop, req;

  // Credit: in IDLE nothing is in flight, so only buffered entries count.
  assign req = (state_q == ST_IDLE) && (fifo_count < CW'(FIFO_DEPTH))
               && !bus.Redirect && !reset;

  assign bus.imem_req        = req;
  assign bus.imem_addr       = pc_q;
  assign bus.out_Valid       = (fifo_count != '0);
  assign bus.out_PC_4        = bus.out_Valid ? fifo_head.pc_4  : RESET_PC;
  assign bus.out_Instruction = bus.out_Valid ? fifo_head.instr : NOP_INSTR;

  assign pop              = bus.out_Valid && !bus.Block_IF_ID_Write && !bus.Redirect;
  assign push_entry.pc_4  = req_pc_4_q;
  assign push_entry.instr = bus.imem_rdata;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_pc_4_d = req_pc_4_q;
    push       = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (req && bus.imem_gnt) begin
          pc_d       = pc_q + 32'd4;
          req_pc_4_d = pc_q + 32'd4;
          state_d    = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // a word landing together with a redirect is stale and already consumed
        if (bus.imem_rvalid) begin
          push    = !bus.Redirect;
          state_d = ST_IDLE;
        end else if (bus.Redirect) begin
          state_d = ST_DISCARD;
        end
      end
      ST_DISCARD: begin
        if (bus.imem_rvalid) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (bus.Redirect) pc_d = word_align(bus.Redirect_PC);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_PC;
      req_pc_4_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_pc_4_q <= req_pc_4_d;
    end
  end

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (bus.Redirect),
    .count     (fifo_count),
    .head      (fifo_head)
  );

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - scoreboard bench for if_fetch_unit with a randomized memory model
module tb_if_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0040_0000;
  localparam int          DEPTH  = 2;

  typedef struct {
    logic [31:0] pc_4;
    logic [31:0] instr;
  } exp_t;

  logic clk = 1'b0;
  logic reset;

  if_fetch_unit_if bus();

  if_fetch_unit #(.RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          pops   = 0;
  exp_t        exp_q[$];
  bit          pend_v;
  logic [31:0] pend_addr;
  int          pend_dly;
  int          gnt_pct, lat_lo, lat_hi;
  bit          force_stale;
  bit          last_hs;
  int          hs_count;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0040_0000) return 32'h2008_0005;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Program order from a fetch target: sequential words, each tagged with its own address + 4.
  task automatic sb_restart(input logic [31:0] target);
    logic [31:0] a;
    exp_t        e;
    exp_q.delete();
    a = target & 32'hFFFF_FFFC;
    for (int k = 0; k < 64; k++) begin
      e.pc_4  = a + 32'd4;
      e.instr = mem_word(a);
      exp_q.push_back(e);
      a = a + 32'd4;
    end
  endtask

  task automatic step(input bit blk, input bit redir, input logic [31:0] target);
    @(negedge clk);
    bus.Block_IF_ID_Write = blk;
    bus.Redirect          = redir;
    bus.Redirect_PC       = target;
    bus.imem_gnt          = ($urandom_range(0, 99) < gnt_pct);
    if (force_stale) begin
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = 32'hDEAD_BEEF;
    end else if (pend_v && pend_dly == 0) begin
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = mem_word(pend_addr);
    end else begin
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = $urandom;
    end
    #1;
    last_hs = bus.imem_req && bus.imem_gnt;
    if (bus.imem_rvalid && !force_stale) pend_v = 1'b0;
    else if (pend_v) pend_dly--;
    if (last_hs) begin
      checks++;
      if (pend_v) begin
        errors++;
        $display("FAIL one_outstanding: request at %h granted while %h still pending", bus.imem_addr, pend_addr);
      end
      pend_v    = 1'b1;
      pend_addr = bus.imem_addr;
      pend_dly  = $urandom_range(lat_lo, lat_hi);
      hs_count++;
    end
    if (redir) sb_restart(target);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!reset && bus.out_Valid && !bus.Block_IF_ID_Write && !bus.Redirect) begin
        pops++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_underrun: popped out_PC_4 %h with no expected entry", bus.out_PC_4);
        end else begin
          e = exp_q.pop_front();
          chk("pop_pc_4", bus.out_PC_4, e.pc_4);
          chk("pop_instr", bus.out_Instruction, e.instr);
        end
      end
      chk("fifo_no_overflow", 32'(dut.u_fifo.count_q <= DEPTH), 32'd1);
    end
  end

  initial begin : main
    bit found;
    int n;
    reset                 = 1'b1;
    bus.Block_IF_ID_Write = 1'b0;
    bus.Redirect          = 1'b0;
    bus.Redirect_PC       = '0;
    bus.imem_gnt          = 1'b0;
    bus.imem_rvalid       = 1'b0;
    bus.imem_rdata        = '0;
    pend_v = 0; pend_addr = '0; pend_dly = 0;
    gnt_pct = 100; lat_lo = 0; lat_hi = 0;
    force_stale = 0; last_hs = 0; hs_count = 0;
    sb_restart(RST_PC);

    #12;
    chk("rst_valid", bus.out_Valid, 0);
    chk("rst_instr", bus.out_Instruction, 32'h0);
    chk("rst_pc_4", bus.out_PC_4, RST_PC);
    chk("rst_req", bus.imem_req, 0);
    reset = 1'b0;

    // first fetch with 1-cycle memory, then hold the stall for six cycles
    step(1, 0, 0);
    chk("t1_req", bus.imem_req, 1);
    chk("t1_addr", bus.imem_addr, 32'h0040_0000);
    step(1, 0, 0);
    step(1, 0, 0);
    chk("t1_valid", bus.out_Valid, 1);
    chk("t1_pc_4", bus.out_PC_4, 32'h0040_0004);
    chk("t1_instr", bus.out_Instruction, 32'h2008_0005);
    chk("t1_next_addr", bus.imem_addr, 32'h0040_0004);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0);
      chk("t2_head_held", bus.out_PC_4, 32'h0040_0004);
    end
    chk("t2_req_off", bus.imem_req, 0);
    chk("t2_fetched", hs_count, DEPTH);
    step(0, 0, 0);
    step(0, 0, 0);
    chk("t2_second_pc_4", bus.out_PC_4, 32'h0040_0008);

    // redirect while a 3-cycle response is still in flight
    lat_lo = 2; lat_hi = 2;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(0, 0, 0);
      found = last_hs;
    end
    chk("t3_grant_seen", found, 1);
    step(0, 1, 32'h0040_0101);
    chk("t3_no_req_on_redirect", bus.imem_req, 0);
    step(0, 0, 0);
    chk("t3_new_addr", bus.imem_addr, 32'h0040_0100);
    found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      step(0, 0, 0);
      found = bus.out_Valid;
    end
    chk("t3_valid_seen", found, 1);
    chk("t3_first_pc_4", bus.out_PC_4, 32'h0040_0104);

    // redirect coinciding with rvalid under stall, FIFO holding one entry
    lat_lo = 0; lat_hi = 0;
    step(0, 1, 32'h0048_0000);
    n = 0;
    for (int i = 0; i < 20 && n < 2; i++) begin
      step(1, 0, 0);
      if (last_hs) n++;
    end
    chk("t4_two_grants", n, 2);
    step(1, 1, 32'h0050_0000);
    chk("t4_rvalid_with_redirect", bus.imem_rvalid, 1);
    step(1, 0, 0);
    chk("t4_valid", bus.out_Valid, 0);
    chk("t4_instr", bus.out_Instruction, 32'h0);
    chk("t4_pc_4", bus.out_PC_4, RST_PC);
    chk("t4_addr", bus.imem_addr, 32'h0050_0000);
    chk("t4_req", bus.imem_req, 1);

    // PC wrap at the top of the address space
    step(1, 1, 32'hFFFF_FFFC);
    step(1, 0, 0);
    chk("t5_addr", bus.imem_addr, 32'hFFFF_FFFC);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(1, 0, 0);
      found = bus.out_Valid;
    end
    chk("t5_valid_seen", found, 1);
    chk("t5_pc_4", bus.out_PC_4, 32'h0000_0000);
    chk("t5_instr", bus.out_Instruction, mem_word(32'hFFFF_FFFC));
    chk("t5_next_addr", bus.imem_addr, 32'h0000_0000);

    // asynchronous reset in the middle of a WAIT
    lat_lo = 3; lat_hi = 3;
    step(0, 1, 32'h0060_0000);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(0, 0, 0);
      found = last_hs;
    end
    chk("t6_grant_seen", found, 1);
    step(0, 0, 0);
    #2;
    reset = 1'b1;
    #1;
    chk("t6_valid", bus.out_Valid, 0);
    chk("t6_instr", bus.out_Instruction, 32'h0);
    chk("t6_pc_4", bus.out_PC_4, RST_PC);
    chk("t6_req", bus.imem_req, 0);
    pend_v = 0;
    sb_restart(RST_PC);
    gnt_pct = 0;
    step(0, 0, 0);
    reset = 1'b0;
    #1;
    chk("t6_addr_after", bus.imem_addr, RST_PC);
    chk("t6_req_after", bus.imem_req, 1);
    force_stale = 1;
    step(0, 0, 0);
    force_stale = 0;
    step(0, 0, 0);
    chk("t6_stale_dropped", bus.out_Valid, 0);

    // randomized traffic: stalls, grant gaps, variable latency, redirects incl. wrap region
    gnt_pct = 70; lat_lo = 0; lat_hi = 3;
    pops = 0;
    for (int i = 0; i < 2000; i++) begin
      bit          blk, redir;
      logic [31:0] target;
      blk    = ($urandom_range(0, 9) < 3);
      redir  = ($urandom_range(0, 15) == 0) || (exp_q.size() < 4);
      target = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      step(blk, redir, target);
    end
    chk("rand_progress", 32'(pops > 100), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
